// File: rtl/tank_level_monitor_pkg.sv
// Shared definitions for the fertiliser-tank level monitor: state encodings,
// the level fault code and small probe-vector helpers.
package tank_level_monitor_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_LOW    = 3'd1,
    ST_NORMAL = 3'd2,
    ST_FULL   = 3'd3,
    ST_FAULT  = 3'd4
  } tank_state_e;

  localparam logic [2:0] LEVEL_FAULT = 3'd7;
  localparam int unsigned NUM_PROBES = 4;

  // A physically possible probe vector is wet from the bottom up.
  function automatic logic is_thermometer(input logic [3:0] v);
    return (v == 4'b0000) || (v == 4'b0001) || (v == 4'b0011) ||
           (v == 4'b0111) || (v == 4'b1111);
  endfunction

  function automatic logic [2:0] probe_count(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_PROBES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Level state for a consistent vector; 0011 keeps LOW/NORMAL as-is
  // (hysteresis band), steps FULL down to NORMAL and is LOW otherwise.
  function automatic tank_state_e level_state(input logic [3:0] v,
                                              input tank_state_e cur);
    tank_state_e s;
    s = cur;
    case (v)
      4'b0000: s = ST_EMPTY;
      4'b0001: s = ST_LOW;
      4'b0011: begin
        case (cur)
          ST_LOW:    s = ST_LOW;
          ST_NORMAL: s = ST_NORMAL;
          ST_FULL:   s = ST_NORMAL;
          default:   s = ST_LOW;
        endcase
      end
      4'b0111: s = ST_NORMAL;
      4'b1111: s = ST_FULL;
      default: s = cur;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tank_level_monitor_probe_debouncer.sv
// One probe channel: two-flop synchroniser followed by a counting debouncer.
module probe_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic probe_i,
  output logic stable_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       stable_q, stable_d;
  logic [7:0] cnt_q, cnt_d;

  // Count consecutive disagreements; adopt the synchronised value on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Synchroniser, counter and stable value registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= probe_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/tank_level_monitor.sv
// Fertiliser-tank level monitor: debounces four level probes, checks them for
// consistency and classifies the level with hysteresis, driving the refill valve.
module tank_level_monitor
  import tank_level_monitor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned FAULT_CYCLES    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] probe,
  output logic       empty_tank,
  output logic       low_level,
  output logic       full_tank,
  output logic       fill_valve,
  output logic       sensor_fault,
  output logic [2:0] level
);

  localparam logic [7:0] FCNT_LAST = 8'(FAULT_CYCLES - 1);

  logic [3:0]  stable_v;
  tank_state_e state_q, state_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [2:0]  level_q, level_d;
  logic        fill_q, fill_d;
  logic        consistent, fault_cond, fault_done;

  for (genvar g = 0; g < NUM_PROBES; g++) begin : g_probe
    probe_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock   (clock),
      .reset   (reset),
      .probe_i (probe[g]),
      .stable_o(stable_v[g])
    );
  end

  // Next state, fault counter and registered level from the stable vector.
  always_comb begin
    consistent = is_thermometer(stable_v);
    fault_cond = (state_q == ST_FAULT) ? consistent : !consistent;
    fault_done = fault_cond && (fcnt_q == FCNT_LAST);

    state_d = state_q;
    if (fault_done) begin
      state_d = (state_q == ST_FAULT) ? level_state(stable_v, ST_FAULT) : ST_FAULT;
    end else if ((state_q != ST_FAULT) && consistent) begin
      state_d = level_state(stable_v, state_q);
    end

    // Restart the count when crossing the FAULT boundary so the opposite
    // condition always needs a full FAULT_CYCLES run of its own.
    fcnt_d = '0;
    if (((state_d == ST_FAULT) != (state_q == ST_FAULT)) || !fault_cond) begin
      fcnt_d = '0;
    end else if (fcnt_q == FCNT_LAST) begin
      fcnt_d = fcnt_q;
    end else begin
      fcnt_d = fcnt_q + 8'd1;
    end

    level_d = (state_d == ST_FAULT) ? LEVEL_FAULT : probe_count(stable_v);
  end

  // Valve opens while low, closes at full or on fault, otherwise holds.
  always_comb begin
    fill_d = fill_q;
    case (state_q)
      ST_EMPTY, ST_LOW: fill_d = 1'b1;
      ST_FULL, ST_FAULT: fill_d = 1'b0;
      default: fill_d = fill_q;
    endcase
  end

  // State, fault counter, level and valve registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      fcnt_q  <= '0;
      level_q <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      level_q <= level_d;
      fill_q  <= fill_d;
    end
  end

  assign empty_tank   = (state_q == ST_EMPTY) || (state_q == ST_FAULT);
  assign low_level    = (state_q == ST_EMPTY) || (state_q == ST_LOW) || (state_q == ST_FAULT);
  assign full_tank    = (state_q == ST_FULL);
  assign sensor_fault = (state_q == ST_FAULT);
  assign level        = level_q;
  assign fill_valve   = fill_q;

endmodule

// File: tb/tb_tank_level_monitor.sv
// Self-checking bench for tank_level_monitor (DEBOUNCE_CYCLES=8, FAULT_CYCLES=16).
// Expected output vectors {empty,low,full,valve,fault,level[2:0]} are queued
// with the edge at which they are due and compared when that edge is reached.
module tb_tank_level_monitor;

  logic       clock;
  logic       reset;
  logic [3:0] probe;
  logic       empty_tank, low_level, full_tank, fill_valve, sensor_fault;
  logic [2:0] level;

  tank_level_monitor #(
    .DEBOUNCE_CYCLES(8),
    .FAULT_CYCLES   (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .probe       (probe),
    .empty_tank  (empty_tank),
    .low_level   (low_level),
    .full_tank   (full_tank),
    .fill_valve  (fill_valve),
    .sensor_fault(sensor_fault),
    .level       (level)
  );

  typedef struct {
    string      name;
    int         due;
    logic [7:0] val;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t it;
  int vectors;
  int miscompares;
  int edges;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] outs();
    return {empty_tank, low_level, full_tank, fill_valve, sensor_fault, level};
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
    edges++;
  endtask

  task automatic expect_at(input string name, input int off, input logic [7:0] val);
    sb_item_t e;
    e.name = name;
    e.due  = edges + off;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    probe = 4'b0000;
    step();
    step();
    expect_at("reset_values", 0, 8'b1100_0000);
    it = sb.pop_front();
    vectors++;
    if (outs() !== it.val) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
    end
    reset = 1'b0;
    expect_at("valve_closed_before_edge", 0, 8'b1100_0000);
    it = sb.pop_front();
    vectors++;
    if (outs() !== it.val) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
    end
    expect_at("valve_first_edge", 1, 8'b1101_0000);
    expect_at("empty_hold", 5, 8'b1101_0000);
    for (int c = 0; c < 6; c++) begin
      step();
      while (sb.size() != 0 && sb[0].due <= edges) begin
        it = sb.pop_front();
        vectors++;
        if (outs() !== it.val) begin
          miscompares++;
          $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
        end
      end
    end
  endtask

  task automatic test_fill();
    logic [3:0] pv [4];
    pv = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int p = 0; p < 4; p++) begin
      probe = pv[p];
      case (p)
        0: begin
          expect_at("fill0001_pre", 10, 8'b1101_0000);
          expect_at("fill0001_low", 11, 8'b0101_0001);
          expect_at("fill0001_hold", 20, 8'b0101_0001);
        end
        1: begin
          expect_at("fill0011_pre", 10, 8'b0101_0001);
          expect_at("fill0011_low", 11, 8'b0101_0010);
        end
        2: begin
          expect_at("fill0111_pre", 10, 8'b0101_0010);
          expect_at("fill0111_normal", 11, 8'b0001_0011);
          expect_at("fill0111_hold", 20, 8'b0001_0011);
        end
        default: begin
          expect_at("fill1111_pre", 10, 8'b0001_0011);
          expect_at("fill1111_full", 11, 8'b0011_0100);
          expect_at("fill1111_valve", 12, 8'b0010_0100);
          expect_at("fill1111_hold", 20, 8'b0010_0100);
        end
      endcase
      for (int c = 0; c < 20; c++) begin
        step();
        while (sb.size() != 0 && sb[0].due <= edges) begin
          it = sb.pop_front();
          vectors++;
          if (outs() !== it.val) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
          end
        end
      end
    end
  endtask

  task automatic test_drain();
    logic [3:0] pv [4];
    pv = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    for (int p = 0; p < 4; p++) begin
      probe = pv[p];
      case (p)
        0: begin
          expect_at("drain0111_pre", 10, 8'b0010_0100);
          expect_at("drain0111_normal", 11, 8'b0000_0011);
        end
        1: begin
          expect_at("drain0011_normal", 11, 8'b0000_0010);
          expect_at("drain0011_hold", 20, 8'b0000_0010);
        end
        2: begin
          expect_at("drain0001_pre", 10, 8'b0000_0010);
          expect_at("drain0001_low", 11, 8'b0100_0001);
          expect_at("drain0001_valve", 12, 8'b0101_0001);
        end
        default: begin
          expect_at("drain0000_empty", 11, 8'b1101_0000);
          expect_at("drain0000_hold", 20, 8'b1101_0000);
        end
      endcase
      for (int c = 0; c < 20; c++) begin
        step();
        while (sb.size() != 0 && sb[0].due <= edges) begin
          it = sb.pop_front();
          vectors++;
          if (outs() !== it.val) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
          end
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] pv [4];
    int hold [4];
    pv   = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    hold = '{7, 25, 8, 25};
    for (int p = 0; p < 4; p++) begin
      probe = pv[p];
      case (p)
        0: expect_at("glitch7_during", 7, 8'b1101_0000);
        1: begin
          expect_at("glitch7_after1", 1, 8'b1101_0000);
          expect_at("glitch7_after11", 11, 8'b1101_0000);
          expect_at("glitch7_after20", 20, 8'b1101_0000);
          expect_at("glitch7_after25", 25, 8'b1101_0000);
        end
        2: expect_at("pulse8_during", 8, 8'b1101_0000);
        default: begin
          expect_at("pulse8_low", 3, 8'b0101_0001);
          expect_at("pulse8_low_hold", 10, 8'b0101_0001);
          expect_at("pulse8_back_empty", 11, 8'b1101_0000);
          expect_at("pulse8_settled", 25, 8'b1101_0000);
        end
      endcase
      for (int c = 0; c < hold[p]; c++) begin
        step();
        while (sb.size() != 0 && sb[0].due <= edges) begin
          it = sb.pop_front();
          vectors++;
          if (outs() !== it.val) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
          end
        end
      end
    end
  endtask

  task automatic test_fault();
    logic [3:0] pv [2];
    pv = '{4'b0101, 4'b1111};
    for (int p = 0; p < 2; p++) begin
      probe = pv[p];
      if (p == 0) begin
        expect_at("fault_stable_pre", 10, 8'b1101_0000);
        expect_at("fault_inconsistent_hold", 11, 8'b1101_0010);
        expect_at("fault_pre_entry", 25, 8'b1101_0010);
        expect_at("fault_entry", 26, 8'b1101_1111);
        expect_at("fault_valve_closed", 27, 8'b1100_1111);
        expect_at("fault_hold", 30, 8'b1100_1111);
      end else begin
        expect_at("fault_recover_pre", 25, 8'b1100_1111);
        expect_at("fault_recover_full", 26, 8'b0010_0100);
        expect_at("fault_recover_hold", 30, 8'b0010_0100);
      end
      for (int c = 0; c < 30; c++) begin
        step();
        while (sb.size() != 0 && sb[0].due <= edges) begin
          it = sb.pop_front();
          vectors++;
          if (outs() !== it.val) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_fault();
    probe = 4'b0101;
    expect_at("rmf_full_pre", 10, 8'b0010_0100);
    expect_at("rmf_full_level2", 11, 8'b0010_0010);
    expect_at("rmf_fault_entry", 26, 8'b1100_1111);
    for (int c = 0; c < 30; c++) begin
      step();
      while (sb.size() != 0 && sb[0].due <= edges) begin
        it = sb.pop_front();
        vectors++;
        if (outs() !== it.val) begin
          miscompares++;
          $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
        end
      end
    end
    #1 reset = 1'b1;
    #1;
    expect_at("rmf_async_reset", 0, 8'b1100_0000);
    it = sb.pop_front();
    vectors++;
    if (outs() !== it.val) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
    end
    probe = 4'b0011;
    step();
    step();
    reset = 1'b0;
    expect_at("rmf_first_edge", 1, 8'b1101_0000);
    expect_at("rmf_pre_low", 10, 8'b1101_0000);
    expect_at("rmf_low", 11, 8'b0101_0010);
    for (int c = 0; c < 12; c++) begin
      step();
      while (sb.size() != 0 && sb[0].due <= edges) begin
        it = sb.pop_front();
        vectors++;
        if (outs() !== it.val) begin
          miscompares++;
          $display("FAIL %s: got %b expected %b", it.name, outs(), it.val);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    edges       = 0;
    reset       = 1'b1;
    probe       = 4'b0000;
    test_reset();
    test_fill();
    test_drain();
    test_glitch();
    test_fault();
    test_reset_mid_fault();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
